random_block_collector: RTL and testbench

RANDOM_BLOCK_COLLECTOR -- requirements
Module: random_block_collector

---
 rtl/random_block_collector.sv | 143 ++++++++++++++
 tb/tb_random_block_collector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/random_block_collector.sv
// Random block collector.
// Requests a burst of REGISTER_SIZE-bit words from an external generator and
// assembles NUM_BLOCKS of them into one number. The held number can then be
// read back one block per cycle until it is consumed.
//
// Ports:
//   clk_in         - single clock, rising edge
//   rst_in         - synchronous active-low reset
//   start_in       - request collection of a new number
//   trigger_out    - one-cycle pulse that starts the generator burst
//   block_in       - generator data word
//   block_valid_in - qualifies block_in
//   busy_out       - request or collection in progress
//   ready_out      - a complete number is held
//   rd_en_in       - read strobe
//   rd_idx_in      - block index to read
//   rd_data_out    - read data, one cycle after rd_en_in
//   rd_valid_out   - qualifies rd_data_out
//   consume_in     - release the held number
//   error_out      - sticky flag for block_valid_in outside collection
module random_block_collector #(
    parameter int unsigned REGISTER_SIZE = 32,
    parameter int unsigned NUM_BLOCKS    = 128
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    output logic                          trigger_out,
    input  logic [REGISTER_SIZE-1:0]      block_in,
    input  logic                          block_valid_in,
    output logic                          busy_out,
    output logic                          ready_out,
    input  logic                          rd_en_in,
    input  logic [$clog2(NUM_BLOCKS)-1:0] rd_idx_in,
    output logic [REGISTER_SIZE-1:0]      rd_data_out,
    output logic                          rd_valid_out,
    input  logic                          consume_in,
    output logic                          error_out
);

    localparam int unsigned IdxW = $clog2(NUM_BLOCKS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRequest,
        StCollect,
        StReady
    } state_e;

    state_e                   state_q, state_d;
    logic [IdxW-1:0]          cnt_q, cnt_d;
    logic                     trigger_q, trigger_d;
    logic                     busy_q, busy_d;
    logic                     ready_q, ready_d;
    logic                     error_q, error_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [REGISTER_SIZE-1:0] rd_data_q, rd_data_d;
    logic                     wr_en;

    // Number storage; never read outside StReady, so it needs no reset.
    logic [REGISTER_SIZE-1:0] buffer_q [NUM_BLOCKS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        wr_en   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_in) state_d = StRequest;
            end
            StRequest: begin
                state_d = StCollect;
                cnt_d   = '0;
            end
            StCollect: begin
                if (block_valid_in) begin
                    wr_en = 1'b1;
                    // Last block completes the number; the counter stops here.
                    if (cnt_q == LastIdx) begin
                        state_d = StReady;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StReady: begin
                if (consume_in) state_d = start_in ? StRequest : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (block_valid_in && (state_q != StCollect)) error_d = 1'b1;
        // A new request always starts with a clean error flag.
        if (state_d == StRequest) error_d = 1'b0;

        // Outputs registered from the next state so they line up with it.
        trigger_d = (state_d == StRequest);
        busy_d    = (state_d == StRequest) || (state_d == StCollect);
        ready_d   = (state_d == StReady);

        // Reads sample the current state, so a read alongside consume_in still hits.
        rd_valid_d = rd_en_in && (state_q == StReady);
        rd_data_d  = rd_data_q;
        if (rd_valid_d) rd_data_d = buffer_q[rd_idx_in];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            trigger_q  <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            trigger_q  <= trigger_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && wr_en) buffer_q[cnt_q] <= block_in;
    end

    assign trigger_out  = trigger_q;
    assign busy_out     = busy_q;
    assign ready_out    = ready_q;
    assign error_out    = error_q;
    assign rd_valid_out = rd_valid_q;
    assign rd_data_out  = rd_data_q;

endmodule

// File: tb/tb_random_block_collector.sv
module tb_random_block_collector;

    localparam int RS = 32;
    localparam int NB = 128;
    localparam int IW = 7;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic          trigger_out;
    logic [RS-1:0] block_in;
    logic          block_valid_in;
    logic          busy_out;
    logic          ready_out;
    logic          rd_en_in;
    logic [IW-1:0] rd_idx_in;
    logic [RS-1:0] rd_data_out;
    logic          rd_valid_out;
    logic          consume_in;
    logic          error_out;

    always #5 clk_in = ~clk_in;

    random_block_collector #(
        .REGISTER_SIZE(RS),
        .NUM_BLOCKS   (NB)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start_in      (start_in),
        .trigger_out   (trigger_out),
        .block_in      (block_in),
        .block_valid_in(block_valid_in),
        .busy_out      (busy_out),
        .ready_out     (ready_out),
        .rd_en_in      (rd_en_in),
        .rd_idx_in     (rd_idx_in),
        .rd_data_out   (rd_data_out),
        .rd_valid_out  (rd_valid_out),
        .consume_in    (consume_in),
        .error_out     (error_out)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases: requesting (one cycle), collecting (word list grows), held (number stored).
    bit          m_live = 1'b0;
    bit          m_req, m_coll, m_held, m_err, m_rdv;
    logic [31:0] m_rdd;
    logic [31:0] m_words[$];
    logic [31:0] m_num[NB];

    task automatic model_step();
        bit begin_req;
        if (!rst_in) begin
            m_req = 0; m_coll = 0; m_held = 0; m_err = 0; m_rdv = 0;
            m_words.delete();
            return;
        end
        m_rdv = m_held && rd_en_in;
        if (m_rdv) m_rdd = m_num[rd_idx_in];
        if (block_valid_in && !m_coll) m_err = 1;
        begin_req = 0;
        if (m_req) begin
            m_req = 0;
            m_coll = 1;
            m_words.delete();
        end else if (m_coll) begin
            if (block_valid_in) begin
                m_words.push_back(block_in);
                if (m_words.size() == NB) begin
                    m_coll = 0;
                    m_held = 1;
                    for (int i = 0; i < NB; i++) m_num[i] = m_words[i];
                end
            end
        end else if (m_held) begin
            if (consume_in) begin
                m_held = 0;
                begin_req = start_in;
            end
        end else begin
            begin_req = start_in;
        end
        if (begin_req) begin
            m_req = 1;
            m_err = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_in);
            model_step();
            m_live = 1'b1;
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_in);
            if (m_live) begin
                check("cmp_trigger", 32'(trigger_out), 32'(m_req));
                check("cmp_busy", 32'(busy_out), 32'(m_req | m_coll));
                check("cmp_ready", 32'(ready_out), 32'(m_held));
                check("cmp_error", 32'(error_out), 32'(m_err));
                check("cmp_rd_valid", 32'(rd_valid_out), 32'(m_rdv));
                if (m_rdv) check("cmp_rd_data", rd_data_out, m_rdd);
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] w2(input int i);
        return 32'hC0DE_0000 + 32'(i * 3);
    endfunction

    int trig_cnt;
    int busy_cnt;

    initial begin
        rst_in = 0; start_in = 0; block_in = '0; block_valid_in = 0;
        rd_en_in = 0; rd_idx_in = '0; consume_in = 0;
        tick(); tick();
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd0);
        check("rst_trigger", 32'(trigger_out), 32'd0);
        check("rst_error", 32'(error_out), 32'd0);
        check("rst_rd_valid", 32'(rd_valid_out), 32'd0);
        rst_in = 1;
        tick();

        // Contiguous burst 0..127.
        trig_cnt = 0;
        start_in = 1; tick(); start_in = 0;
        check("s1_trigger_req", 32'(trigger_out), 32'd1);
        trig_cnt += int'(trigger_out);
        tick();
        trig_cnt += int'(trigger_out);
        for (int i = 0; i < NB; i++) begin
            block_valid_in = 1; block_in = 32'(i);
            tick();
            trig_cnt += int'(trigger_out);
            if (i == NB - 2) check("s1_ready_early", 32'(ready_out), 32'd0);
        end
        block_valid_in = 0;
        check("s1_ready_after_7f", 32'(ready_out), 32'd1);
        check("s1_trigger_count", 32'(trig_cnt), 32'd1);
        rd_en_in = 1; rd_idx_in = 7'd5; tick(); rd_en_in = 0;
        check("s1_rd_valid", 32'(rd_valid_out), 32'd1);
        check("s1_rd_data_5", rd_data_out, 32'h0000_0005);

        // Toggling valid: 128 words over 256 cycles.
        consume_in = 1; tick(); consume_in = 0;
        start_in = 1; tick(); start_in = 0;
        busy_cnt = int'(busy_out);
        tick();
        for (int c = 0; c < 256; c++) begin
            block_valid_in = (c % 2 == 0);
            block_in = block_valid_in ? w2(c / 2) : 32'hDEAD_BEEF;
            tick();
            if (c < 254) busy_cnt += int'(busy_out);
            if (c == 253) check("s2_ready_early", 32'(ready_out), 32'd0);
        end
        block_valid_in = 0;
        check("s2_busy_cycles", 32'(busy_cnt), 32'd255);
        check("s2_ready", 32'(ready_out), 32'd1);
        check("s2_busy_after", 32'(busy_out), 32'd0);

        // Back-to-back reads 0, 127, 64.
        rd_en_in = 1;
        rd_idx_in = 7'd0; tick();
        check("s3_rdv0", 32'(rd_valid_out), 32'd1);
        check("s3_rd0", rd_data_out, 32'hC0DE_0000);
        rd_idx_in = 7'd127; tick();
        check("s3_rdv127", 32'(rd_valid_out), 32'd1);
        check("s3_rd127", rd_data_out, 32'hC0DE_017D);
        rd_idx_in = 7'd64; tick();
        check("s3_rdv64", 32'(rd_valid_out), 32'd1);
        check("s3_rd64", rd_data_out, 32'hC0DE_00C0);
        rd_en_in = 0; tick();
        check("s3_rdv_off", 32'(rd_valid_out), 32'd0);

        // Stray valid in IDLE.
        consume_in = 1; tick(); consume_in = 0;
        check("s4_idle_ready", 32'(ready_out), 32'd0);
        block_valid_in = 1; block_in = 32'h1234_5678; tick(); block_valid_in = 0;
        check("s4_error_set", 32'(error_out), 32'd1);
        check("s4_no_busy", 32'(busy_out), 32'd0);
        check("s4_no_ready", 32'(ready_out), 32'd0);
        tick();
        check("s4_error_sticky", 32'(error_out), 32'd1);
        start_in = 1; tick(); start_in = 0;
        check("s4_error_clear", 32'(error_out), 32'd0);
        check("s4_trigger", 32'(trigger_out), 32'd1);

        // Reset after 40 words, then a fresh burst.
        tick();
        for (int i = 0; i < 40; i++) begin
            block_valid_in = 1; block_in = 32'h5555_0000 + 32'(i); tick();
        end
        block_valid_in = 0;
        rst_in = 0; tick(); rst_in = 1;
        check("s5_rst_busy", 32'(busy_out), 32'd0);
        check("s5_rst_ready", 32'(ready_out), 32'd0);
        start_in = 1; tick(); start_in = 0; tick();
        for (int i = 0; i < NB; i++) begin
            block_valid_in = 1; block_in = 32'hA000_0000 + 32'(i); tick();
            if (i == NB - 2) check("s5_ready_early", 32'(ready_out), 32'd0);
        end
        block_valid_in = 0;
        check("s5_ready", 32'(ready_out), 32'd1);
        rd_en_in = 1; rd_idx_in = 7'd0; tick();
        check("s5_rd0", rd_data_out, 32'hA000_0000);
        rd_idx_in = 7'd39; tick(); rd_en_in = 0;
        check("s5_rd39", rd_data_out, 32'hA000_0027);

        // consume + start together in READY.
        consume_in = 1; start_in = 1; tick(); consume_in = 0; start_in = 0;
        check("s6_trigger", 32'(trigger_out), 32'd1);
        check("s6_ready_fell", 32'(ready_out), 32'd0);
        check("s6_busy", 32'(busy_out), 32'd1);

        // Random phase, checked by the compare process against the model.
        for (int c = 0; c < 6000; c++) begin
            rst_in         = ($urandom % 400) != 0;
            start_in       = ($urandom % 8) == 0;
            consume_in     = ($urandom % 16) == 0;
            block_valid_in = ($urandom % 4) != 0;
            block_in       = $urandom;
            rd_en_in       = $urandom % 2;
            rd_idx_in      = IW'($urandom % NB);
            tick();
        end
        rst_in = 1; start_in = 0; consume_in = 0; block_valid_in = 0; rd_en_in = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
